// File: rtl/lbw_pkg.sv
// Shared definitions for the latch bank write controller: FSM encoding and a
// constant-foldable clog2 helper for port/localparam sizing.
package lbw_pkg;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_SETUP  = 2'd1,
        ST_ENABLE = 2'd2,
        ST_HOLD   = 2'd3
    } state_e;

    function automatic int unsigned clog2(input int unsigned v);
        int unsigned r;
        r = 0;
        for (int unsigned i = 0; i < 32; i++) begin
            if ((32'd1 << i) < v) r = i + 1;
        end
        return r;
    endfunction

endpackage

// File: rtl/rr_arbiter.sv
// Combinational round-robin pick: first unmasked request at or above ptr,
// wrapping modulo NREQ.
module rr_arbiter #(
    parameter int unsigned NREQ = 4,
    parameter int unsigned IW   = 2
) (
    input  logic [NREQ-1:0] req,
    input  logic [NREQ-1:0] mask,
    input  logic [IW-1:0]   ptr,
    output logic            gnt_valid,
    output logic [IW-1:0]   gnt_id
);

    logic [NREQ-1:0] eligible;
    int unsigned     idx;

    always_comb begin
        eligible  = req & ~mask;
        gnt_valid = 1'b0;
        gnt_id    = '0;
        idx       = 0;
        for (int unsigned k = 0; k < NREQ; k++) begin
            idx = (32'(ptr) + k) % NREQ;
            if (!gnt_valid && eligible[IW'(idx)]) begin
                gnt_valid = 1'b1;
                gnt_id    = IW'(idx);
            end
        end
    end

endmodule

// File: rtl/latch_bank_write_ctrl.sv
// Round-robin write sequencer for a bank of level-sensitive storage cells.
// Each write runs SETUP -> ENABLE -> HOLD so data/select are stable under lat_en.
module latch_bank_write_ctrl
    import lbw_pkg::*;
#(
    parameter  int unsigned NREQ   = 4,
    parameter  int unsigned DW     = 8,
    parameter  int unsigned DEPTH  = 4,
    localparam int unsigned AW     = clog2(DEPTH),
    localparam int unsigned AW_REQ = clog2(NREQ)
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic [NREQ-1:0]      req,
    input  logic [NREQ*AW-1:0]   wr_addr,
    input  logic [NREQ*DW-1:0]   wr_data,
    output logic [NREQ-1:0]      ack,
    output logic                 err,
    output logic [DW-1:0]        lat_d,
    output logic [DEPTH-1:0]     lat_en,
    output logic                 busy,
    output logic [AW_REQ-1:0]    grant_id
);

    state_e              state_q, state_d;
    logic [AW_REQ-1:0]   ptr_q, ptr_d;
    logic [AW-1:0]       addr_q, addr_d;
    logic [DW-1:0]       lat_d_q, lat_d_d;
    logic [DEPTH-1:0]    lat_en_q, lat_en_d;
    logic [NREQ-1:0]     ack_q, ack_d;
    logic                err_q, err_d;
    logic                busy_q, busy_d;
    logic [AW_REQ-1:0]   grant_id_q, grant_id_d;

    logic [NREQ-1:0]     arb_mask;
    logic                gnt_valid;
    logic [AW_REQ-1:0]   gnt_id;
    logic [DEPTH-1:0]    en_dec;
    logic                addr_oor;

    // The requester being acked this cycle sits out the re-arbitration.
    always_comb begin
        arb_mask = '0;
        if (state_q == ST_HOLD) arb_mask[grant_id_q] = 1'b1;
    end

    rr_arbiter #(
        .NREQ (NREQ),
        .IW   (AW_REQ)
    ) u_arb (
        .req       (req),
        .mask      (arb_mask),
        .ptr       (ptr_q),
        .gnt_valid (gnt_valid),
        .gnt_id    (gnt_id)
    );

    always_comb begin
        en_dec = '0;
        for (int unsigned i = 0; i < DEPTH; i++) begin
            en_dec[i] = (addr_q == AW'(i));
        end
        addr_oor = (32'(addr_q) >= DEPTH);
    end

    always_comb begin
        state_d    = state_q;
        ptr_d      = ptr_q;
        addr_d     = addr_q;
        lat_d_d    = lat_d_q;
        lat_en_d   = '0;
        ack_d      = '0;
        err_d      = 1'b0;
        busy_d     = busy_q;
        grant_id_d = grant_id_q;

        unique case (state_q)
            ST_IDLE, ST_HOLD: begin
                if (gnt_valid) begin
                    state_d    = ST_SETUP;
                    busy_d     = 1'b1;
                    grant_id_d = gnt_id;
                    ptr_d      = AW_REQ'((32'(gnt_id) + 32'd1) % NREQ);
                    addr_d     = wr_addr[32'(gnt_id)*AW +: AW];
                    lat_d_d    = wr_data[32'(gnt_id)*DW +: DW];
                end else begin
                    state_d = ST_IDLE;
                    busy_d  = 1'b0;
                end
            end
            ST_SETUP: begin
                state_d  = ST_ENABLE;
                lat_en_d = en_dec;
            end
            ST_ENABLE: begin
                state_d           = ST_HOLD;
                ack_d[grant_id_q] = 1'b1;
                err_d             = addr_oor;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= ST_IDLE;
            ptr_q      <= '0;
            addr_q     <= '0;
            lat_d_q    <= '0;
            lat_en_q   <= '0;
            ack_q      <= '0;
            err_q      <= 1'b0;
            busy_q     <= 1'b0;
            grant_id_q <= '0;
        end else begin
            state_q    <= state_d;
            ptr_q      <= ptr_d;
            addr_q     <= addr_d;
            lat_d_q    <= lat_d_d;
            lat_en_q   <= lat_en_d;
            ack_q      <= ack_d;
            err_q      <= err_d;
            busy_q     <= busy_d;
            grant_id_q <= grant_id_d;
        end
    end

    assign ack      = ack_q;
    assign err      = err_q;
    assign lat_d    = lat_d_q;
    assign lat_en   = lat_en_q;
    assign busy     = busy_q;
    assign grant_id = grant_id_q;

endmodule

// File: tb/tb_latch_bank_write_ctrl.sv
// Directed bench for latch_bank_write_ctrl: a scoreboard of expected writes
// (DEPTH=4 instance) plus direct checks on a DEPTH=3 instance for range errors.
module tb_latch_bank_write_ctrl;

    logic        clk = 1'b0;
    logic        rst = 1'b1;

    logic [3:0]  req = '0;
    logic [7:0]  wr_addr = '0;
    logic [31:0] wr_data = '0;
    logic [3:0]  ack;
    logic        err;
    logic [7:0]  lat_d;
    logic [3:0]  lat_en;
    logic        busy;
    logic [1:0]  grant_id;

    logic [3:0]  req3 = '0;
    logic [7:0]  wr_addr3 = '0;
    logic [31:0] wr_data3 = '0;
    logic [3:0]  ack3;
    logic        err3;
    logic [7:0]  lat_d3;
    logic [2:0]  lat_en3;
    logic        busy3;
    logic [1:0]  grant_id3;

    typedef struct {
        int         id;
        logic [7:0] data;
        logic [3:0] en;
    } exp_t;

    exp_t        sb[$];
    exp_t        e;
    logic [3:0]  en_seen = '0;
    logic [7:0]  prev_lat_d = '0;
    int          vectors = 0;
    int          miscompares = 0;

    always #5 clk = ~clk;

    latch_bank_write_ctrl #(.NREQ(4), .DW(8), .DEPTH(4)) u_dut (
        .clk(clk), .rst(rst), .req(req), .wr_addr(wr_addr), .wr_data(wr_data),
        .ack(ack), .err(err), .lat_d(lat_d), .lat_en(lat_en), .busy(busy),
        .grant_id(grant_id)
    );

    latch_bank_write_ctrl #(.NREQ(4), .DW(8), .DEPTH(3)) u_dut3 (
        .clk(clk), .rst(rst), .req(req3), .wr_addr(wr_addr3), .wr_data(wr_data3),
        .ack(ack3), .err(err3), .lat_d(lat_d3), .lat_en(lat_en3), .busy(busy3),
        .grant_id(grant_id3)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic set_req(input int id, input logic [1:0] a, input logic [7:0] d);
        wr_addr[id*2 +: 2] = a;
        wr_data[id*8 +: 8] = d;
        req[id]            = 1'b1;
    endtask

    task automatic push(input int id, input logic [1:0] a, input logic [7:0] d);
        exp_t x;
        x.id   = id;
        x.data = d;
        x.en   = 4'(32'd1 << a);
        sb.push_back(x);
    endtask

    // One clock; sample away from the edge, score any ack, drop acked requests.
    task automatic step();
        @(posedge clk);
        #1;
        if (lat_en != 4'b0) begin
            chk("lat_en_onehot", 32'($onehot(lat_en)), 32'd1);
            chk("lat_d_stable", 32'(lat_d), 32'(prev_lat_d));
            en_seen = lat_en;
        end
        if (ack != 4'b0) begin
            if (sb.size() == 0) begin
                chk("ack_unexpected", 32'(ack), 32'd0);
            end else begin
                e = sb.pop_front();
                chk("sb_ack", 32'(ack), 32'd1 << e.id);
                chk("sb_err", 32'(err), 32'd0);
                chk("sb_lat_d", 32'(lat_d), 32'(e.data));
                chk("sb_lat_en", 32'(en_seen), 32'(e.en));
            end
            en_seen = '0;
        end
        req        = req & ~ack;
        req3       = req3 & ~ack3;
        prev_lat_d = lat_d;
    endtask

    initial begin
        // Reset state
        rst = 1'b1;
        step();
        step();
        chk("rst_lat_d", 32'(lat_d), 32'd0);
        chk("rst_lat_en", 32'(lat_en), 32'd0);
        chk("rst_ack", 32'(ack), 32'd0);
        chk("rst_err", 32'(err), 32'd0);
        chk("rst_busy", 32'(busy), 32'd0);
        chk("rst_grant_id", 32'(grant_id), 32'd0);
        chk("rst_busy3", 32'(busy3), 32'd0);
        rst = 1'b0;

        // Single write latency
        set_req(0, 2'd2, 8'hA5);
        push(0, 2'd2, 8'hA5);
        step();
        chk("single_setup_lat_d", 32'(lat_d), 32'hA5);
        chk("single_setup_lat_en", 32'(lat_en), 32'd0);
        chk("single_setup_busy", 32'(busy), 32'd1);
        step();
        chk("single_enable_lat_en", 32'(lat_en), 32'h4);
        step();
        chk("single_hold_ack", 32'(ack), 32'h1);
        chk("single_hold_lat_en", 32'(lat_en), 32'd0);
        step();
        chk("single_idle_busy", 32'(busy), 32'd0);
        chk("single_idle_ack", 32'(ack), 32'd0);

        // Round-robin from a fresh pointer: acks 0,1,2,3 every third cycle
        rst = 1'b1;
        step();
        rst = 1'b0;
        set_req(0, 2'd0, 8'h10);
        set_req(1, 2'd1, 8'h21);
        set_req(2, 2'd2, 8'h32);
        set_req(3, 2'd3, 8'h43);
        push(0, 2'd0, 8'h10);
        push(1, 2'd1, 8'h21);
        push(2, 2'd2, 8'h32);
        push(3, 2'd3, 8'h43);
        for (int k = 1; k <= 12; k++) begin
            step();
            chk("rr_ack_timing", 32'(ack), (k % 3 == 0) ? (32'd1 << (k / 3 - 1)) : 32'd0);
            chk("rr_busy", 32'(busy), 32'd1);
        end
        step();
        chk("rr_idle_busy", 32'(busy), 32'd0);

        // Fairness wrap: grant to 2 leaves ptr at 3, so 3 beats 0
        set_req(2, 2'd0, 8'h22);
        push(2, 2'd0, 8'h22);
        for (int k = 1; k <= 4; k++) step();
        chk("wrap_pre_busy", 32'(busy), 32'd0);
        set_req(3, 2'd1, 8'h44);
        set_req(0, 2'd3, 8'h66);
        push(3, 2'd1, 8'h44);
        push(0, 2'd3, 8'h66);
        step();
        chk("wrap_first_grant", 32'(grant_id), 32'd3);
        step();
        step();
        step();
        chk("wrap_second_grant", 32'(grant_id), 32'd0);
        chk("wrap_no_idle", 32'(busy), 32'd1);
        step();
        step();
        step();
        chk("wrap_idle_busy", 32'(busy), 32'd0);

        // Out of range on the DEPTH=3 instance, then an in-range write to cell 2
        wr_addr3[1:0] = 2'd3;
        wr_data3[7:0] = 8'h5A;
        req3[0]       = 1'b1;
        for (int k = 1; k <= 4; k++) begin
            step();
            chk("oor_lat_en", 32'(lat_en3), 32'd0);
            chk("oor_ack", 32'(ack3), (k == 3) ? 32'd1 : 32'd0);
            chk("oor_err", 32'(err3), (k == 3) ? 32'd1 : 32'd0);
        end
        chk("oor_idle_busy", 32'(busy3), 32'd0);
        wr_addr3[3:2] = 2'd2;
        wr_data3[15:8] = 8'hC3;
        req3[1]        = 1'b1;
        for (int k = 1; k <= 3; k++) begin
            step();
            chk("inr_lat_en", 32'(lat_en3), (k == 2) ? 32'h4 : 32'd0);
            chk("inr_err", 32'(err3), 32'd0);
        end
        chk("inr_ack", 32'(ack3), 32'h2);
        chk("inr_lat_d", 32'(lat_d3), 32'hC3);
        step();

        // Data stability: winner changes addr/data and drops req mid-transaction
        set_req(1, 2'd1, 8'h3C);
        push(1, 2'd1, 8'h3C);
        step();
        chk("stab_setup_lat_d", 32'(lat_d), 32'h3C);
        wr_addr[3:2]  = 2'd3;
        wr_data[15:8] = 8'hFF;
        step();
        chk("stab_enable_lat_en", 32'(lat_en), 32'h2);
        chk("stab_enable_lat_d", 32'(lat_d), 32'h3C);
        wr_addr[3:2]  = 2'd0;
        wr_data[15:8] = 8'h00;
        req[1]        = 1'b0;
        step();
        chk("stab_hold_ack", 32'(ack), 32'h2);
        chk("stab_hold_lat_d", 32'(lat_d), 32'h3C);
        step();
        chk("stab_idle_busy", 32'(busy), 32'd0);

        // Reset in ENABLE aborts the write and returns ptr to 0
        set_req(1, 2'd3, 8'h11);
        step();
        step();
        chk("abort_enable_lat_en", 32'(lat_en), 32'h8);
        rst = 1'b1;
        step();
        chk("abort_lat_en", 32'(lat_en), 32'd0);
        chk("abort_ack", 32'(ack), 32'd0);
        chk("abort_busy", 32'(busy), 32'd0);
        rst = 1'b0;
        sb.delete();
        en_seen = '0;
        set_req(3, 2'd2, 8'h33);
        push(1, 2'd3, 8'h11);
        push(3, 2'd2, 8'h33);
        step();
        chk("abort_ptr_grant", 32'(grant_id), 32'd1);
        for (int k = 2; k <= 6; k++) step();
        step();
        chk("abort_idle_busy", 32'(busy), 32'd0);
        chk("sb_drain", 32'(sb.size()), 32'd0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
